// File: rtl/reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter
//
// Shared command/status register bank with a two-requester arbiter. The host
// command path and the test sequencer each access the bank through a req/ack
// handshake. Accesses are serialised, and round-robin priority breaks ties.
//
// Ports
//   clk, notReset               : clock, async active-low reset
//   hReq/hWe/hAddr/hWdata       : host request, write enable, address, data
//   hAck/hRdata                 : host one-cycle ack, read data (held after ack)
//   tReq/tWe/tAddr/tWdata       : test-sequencer request (same semantics)
//   tAck/tRdata                 : test-sequencer ack and read data
//   clearAll                    : single-cycle pulse, clears every register
//   addrErr                     : pulses with an ack whose address >= NUM_REGS
//   busy                        : high while an access is in progress
// -----------------------------------------------------------------------------
module reg_bank_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              hReq,
    input  logic              hWe,
    input  logic [ADDR_W-1:0] hAddr,
    input  logic [DATA_W-1:0] hWdata,
    output logic              hAck,
    output logic [DATA_W-1:0] hRdata,
    input  logic              tReq,
    input  logic              tWe,
    input  logic [ADDR_W-1:0] tAddr,
    input  logic [DATA_W-1:0] tWdata,
    output logic              tAck,
    output logic [DATA_W-1:0] tRdata,
    input  logic              clearAll,
    output logic              addrErr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC_H, ACC_T} state_t;

    localparam logic GRANT_H = 1'b0;
    localparam logic GRANT_T = 1'b1;

    // Index width covering exactly NUM_REGS entries; the upper address bits
    // only matter for the range check.
    localparam int              IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

    state_t              state_q,     state_d;
    logic                last_grant_q, last_grant_d;
    logic                clr_pend_q,  clr_pend_d;
    logic                acc_we_q,    acc_we_d;
    logic [ADDR_W-1:0]   acc_addr_q,  acc_addr_d;
    logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                h_ack_q,     h_ack_d;
    logic                t_ack_q,     t_ack_d;
    logic [DATA_W-1:0]   h_rdata_q,   h_rdata_d;
    logic [DATA_W-1:0]   t_rdata_q,   t_rdata_d;
    logic                addr_err_q,  addr_err_d;
    logic                busy_q,      busy_d;

    logic                acc_in_range;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   rd_val;

    assign acc_in_range = ({1'b0, acc_addr_q} < NUM_REGS_C);
    assign acc_idx      = acc_addr_q[IDX_W-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        clr_pend_d   = clr_pend_q;
        acc_we_d     = acc_we_q;
        acc_addr_d   = acc_addr_q;
        acc_wdata_d  = acc_wdata_q;
        regs_d       = regs_q;
        h_rdata_d    = h_rdata_q;
        t_rdata_d    = t_rdata_q;
        h_ack_d      = 1'b0;
        t_ack_d      = 1'b0;
        addr_err_d   = 1'b0;
        rd_val       = '0;

        case (state_q)
            IDLE: begin
                if (clearAll || clr_pend_q) begin
                    // A clear (fresh or deferred) owns this cycle; requests
                    // simply wait one more cycle.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        regs_d[i] = '0;
                    end
                    clr_pend_d = 1'b0;
                end else if (hReq && (!tReq || last_grant_q == GRANT_T)) begin
                    state_d      = ACC_H;
                    last_grant_d = GRANT_H;
                    acc_we_d     = hWe;
                    acc_addr_d   = hAddr;
                    acc_wdata_d  = hWdata;
                end else if (tReq) begin
                    state_d      = ACC_T;
                    last_grant_d = GRANT_T;
                    acc_we_d     = tWe;
                    acc_addr_d   = tAddr;
                    acc_wdata_d  = tWdata;
                end
            end

            ACC_H, ACC_T: begin
                state_d    = IDLE;
                addr_err_d = !acc_in_range;
                // A clear arriving mid-access must not collide with the write.
                if (clearAll) begin
                    clr_pend_d = 1'b1;
                end
                if (acc_we_q) begin
                    if (acc_in_range) begin
                        regs_d[acc_idx] = acc_wdata_q;
                    end
                end else begin
                    rd_val = acc_in_range ? regs_q[acc_idx] : '0;
                    if (state_q == ACC_H) begin
                        h_rdata_d = rd_val;
                    end else begin
                        t_rdata_d = rd_val;
                    end
                end
                if (state_q == ACC_H) begin
                    h_ack_d = 1'b1;
                end else begin
                    t_ack_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_T;
            clr_pend_q   <= 1'b0;
            acc_we_q     <= 1'b0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            // NOTE: the bank is reset because software relies on reading
            // zeros after reset; this keeps it in flops rather than RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            h_ack_q      <= 1'b0;
            t_ack_q      <= 1'b0;
            h_rdata_q    <= '0;
            t_rdata_q    <= '0;
            addr_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            clr_pend_q   <= clr_pend_d;
            acc_we_q     <= acc_we_d;
            acc_addr_q   <= acc_addr_d;
            acc_wdata_q  <= acc_wdata_d;
            regs_q       <= regs_d;
            h_ack_q      <= h_ack_d;
            t_ack_q      <= t_ack_d;
            h_rdata_q    <= h_rdata_d;
            t_rdata_q    <= t_rdata_d;
            addr_err_q   <= addr_err_d;
            busy_q       <= busy_d;
        end
    end

    assign hAck    = h_ack_q;
    assign tAck    = t_ack_q;
    assign hRdata  = h_rdata_q;
    assign tRdata  = t_rdata_q;
    assign addrErr = addr_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Directed bench for reg_bank_arbiter (NUM_REGS=8, DATA_W=32, ADDR_W=4).
// Inputs change and outputs are sampled on the falling clock edge. Each test
// task starts and ends at a falling edge with both requests low and the
// arbiter idle. exp_regs holds the expected bank contents.
// -----------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    logic        clk;
    logic        notReset;
    logic        hReq, hWe, tReq, tWe, clearAll;
    logic [3:0]  hAddr, tAddr;
    logic [31:0] hWdata, tWdata;
    logic        hAck, tAck, addrErr, busy;
    logic [31:0] hRdata, tRdata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_regs [8];

    reg_bank_arbiter #(.NUM_REGS(8), .DATA_W(32), .ADDR_W(4)) dut (
        .clk      (clk),
        .notReset (notReset),
        .hReq     (hReq),
        .hWe      (hWe),
        .hAddr    (hAddr),
        .hWdata   (hWdata),
        .hAck     (hAck),
        .hRdata   (hRdata),
        .tReq     (tReq),
        .tWe      (tWe),
        .tAddr    (tAddr),
        .tWdata   (tWdata),
        .tAck     (tAck),
        .tRdata   (tRdata),
        .clearAll (clearAll),
        .addrErr  (addrErr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic host_drive(input logic req, input logic we,
                              input logic [3:0] addr, input logic [31:0] wdata);
        hReq = req; hWe = we; hAddr = addr; hWdata = wdata;
    endtask

    task automatic test_drive(input logic req, input logic we,
                              input logic [3:0] addr, input logic [31:0] wdata);
        tReq = req; tWe = we; tAddr = addr; tWdata = wdata;
    endtask

    task automatic test_reset;
        notReset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hAck, tAck, addrErr, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got hAck/tAck/addrErr/busy=%b want 0000",
                     {hAck, tAck, addrErr, busy});
        end
        checks++;
        if (hRdata !== 32'h0 || tRdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got h=%h t=%h want 0", hRdata, tRdata);
        end
        notReset = 1'b1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hAck !== 1'b0 || tAck !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b hAck=%b tAck=%b want 0", busy, hAck, tAck);
        end
    endtask

    task automatic test_write_read;
        host_drive(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        exp_regs[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || hAck !== 1'b0) begin
            failures++;
            $display("FAIL wr_grant: got busy=%b hAck=%b want busy=1 hAck=0", busy, hAck);
        end
        @(negedge clk);
        checks++;
        if (hAck !== 1'b1 || busy !== 1'b0 || addrErr !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack: got hAck=%b busy=%b addrErr=%b want 1 0 0", hAck, busy, addrErr);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (hAck !== 1'b0) begin
            failures++;
            $display("FAIL wr_ack_pulse: got hAck=%b want 0", hAck);
        end
        test_drive(1'b1, 1'b0, 4'd3, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || tRdata !== 32'hDEAD_BEEF || hAck !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_wr: got tAck=%b tRdata=%h hAck=%b want 1 deadbeef 0",
                     tAck, tRdata, hAck);
        end
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (tAck !== 1'b0 || tRdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rd_hold: got tAck=%b tRdata=%h want 0 deadbeef", tAck, tRdata);
        end
    endtask

    task automatic test_contention;
        host_drive(1'b1, 1'b1, 4'd1, 32'h11);
        test_drive(1'b1, 1'b1, 4'd1, 32'h22);
        exp_regs[1] = 32'h22;
        repeat (2) @(negedge clk);
        checks++;
        if (hAck !== 1'b1 || tAck !== 1'b0) begin
            failures++;
            $display("FAIL cont_first: got hAck=%b tAck=%b want 1 0", hAck, tAck);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || tAck !== 1'b0) begin
            failures++;
            $display("FAIL cont_loser_grant: got busy=%b tAck=%b want 1 0", busy, tAck);
        end
        @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || hAck !== 1'b0) begin
            failures++;
            $display("FAIL cont_second: got tAck=%b hAck=%b want 1 0", tAck, hAck);
        end
        test_drive(1'b1, 1'b0, 4'd1, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || tRdata !== 32'h22) begin
            failures++;
            $display("FAIL cont_final: got tAck=%b regs[1]=%h want 1 00000022", tAck, tRdata);
        end
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int   n_acks   = 0;
        int   last_cyc = 0;
        logic want_h;
        host_drive(1'b1, 1'b1, 4'd4, 32'h44);
        test_drive(1'b1, 1'b1, 4'd5, 32'h55);
        exp_regs[4] = 32'h44;
        exp_regs[5] = 32'h55;
        for (int cyc = 1; cyc <= 40 && n_acks < 8; cyc++) begin
            @(negedge clk);
            if (hAck || tAck) begin
                want_h = (n_acks % 2 == 0);
                checks++;
                if (hAck !== want_h || tAck !== !want_h) begin
                    failures++;
                    $display("FAIL b2b_order: ack %0d got hAck=%b tAck=%b want %b %b",
                             n_acks, hAck, tAck, want_h, !want_h);
                end
                if (n_acks > 0) begin
                    checks++;
                    if (cyc - last_cyc > 2) begin
                        failures++;
                        $display("FAIL b2b_gap: ack %0d got gap=%0d cycles want <=2",
                                 n_acks, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_acks++;
                if (n_acks == 8) begin
                    host_drive(1'b0, 1'b0, 4'd0, 32'h0);
                    test_drive(1'b0, 1'b0, 4'd0, 32'h0);
                end
            end
        end
        checks++;
        if (n_acks != 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d acks want 8", n_acks);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hAck !== 1'b0 || tAck !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: got busy=%b hAck=%b tAck=%b want 0", busy, hAck, tAck);
        end
    endtask

    task automatic test_addr_err;
        host_drive(1'b1, 1'b1, 4'd9, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (hAck !== 1'b1 || addrErr !== 1'b1) begin
            failures++;
            $display("FAIL err_wr: got hAck=%b addrErr=%b want 1 1", hAck, addrErr);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (addrErr !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: got addrErr=%b want 0", addrErr);
        end
        test_drive(1'b1, 1'b0, 4'd9, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || addrErr !== 1'b1 || tRdata !== 32'h0) begin
            failures++;
            $display("FAIL err_rd: got tAck=%b addrErr=%b tRdata=%h want 1 1 0",
                     tAck, addrErr, tRdata);
        end
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            test_drive(1'b1, 1'b0, 4'(i), 32'h0);
            repeat (2) @(negedge clk);
            checks++;
            if (tAck !== 1'b1 || addrErr !== 1'b0 || tRdata !== exp_regs[i]) begin
                failures++;
                $display("FAIL err_bank: regs[%0d] got tAck=%b addrErr=%b data=%h want 1 0 %h",
                         i, tAck, addrErr, tRdata, exp_regs[i]);
            end
            test_drive(1'b0, 1'b0, 4'd0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_clear_deferred;
        logic seen = 1'b0;
        host_drive(1'b1, 1'b1, 4'd2, 32'h5);
        repeat (2) @(negedge clk);
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        host_drive(1'b1, 1'b0, 4'd2, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (hAck !== 1'b1 || hRdata !== 32'h5) begin
            failures++;
            $display("FAIL clr_pre: got hAck=%b hRdata=%h want 1 00000005", hAck, hRdata);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        // Test read occupies ACC_T; clear and host read arrive during it.
        test_drive(1'b1, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_acc_t: got busy=%b want 1", busy);
        end
        clearAll = 1'b1;
        host_drive(1'b1, 1'b0, 4'd2, 32'h0);
        @(negedge clk);
        clearAll = 1'b0;
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++;
        if (tAck !== 1'b1) begin
            failures++;
            $display("FAIL clr_t_ack: got tAck=%b want 1", tAck);
        end
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (hAck) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL clr_h_ack: got no hAck within 6 cycles want hAck");
        end
        checks++;
        if (hRdata !== 32'h0) begin
            failures++;
            $display("FAIL clr_rd: got hRdata=%h want 0", hRdata);
        end
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        @(negedge clk);
        test_drive(1'b1, 1'b0, 4'd3, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || tRdata !== 32'h0) begin
            failures++;
            $display("FAIL clr_other: got tAck=%b regs[3]=%h want 1 0", tAck, tRdata);
        end
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        host_drive(1'b1, 1'b1, 4'd0, 32'hA5);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_grant: got busy=%b want 1", busy);
        end
        notReset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy_now: got busy=%b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (hAck !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_ack: got hAck=%b busy=%b want 0 0", hAck, busy);
        end
        notReset = 1'b1;
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || hAck !== 1'b0) begin
                failures++;
                $display("FAIL abort_idle: cycle %0d got busy=%b hAck=%b want 0 0", i, busy, hAck);
            end
        end
        test_drive(1'b1, 1'b0, 4'd0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (tAck !== 1'b1 || tRdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_reg: got tAck=%b regs[0]=%h want 1 0", tAck, tRdata);
        end
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        notReset = 1'b0;
        clearAll = 1'b0;
        host_drive(1'b0, 1'b0, 4'd0, 32'h0);
        test_drive(1'b0, 1'b0, 4'd0, 32'h0);
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_addr_err();
        test_clear_deferred();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shared register bank with a two-requester arbiter. It replaces direct, unsynchronised access to the command/status register array. The host command path (JTAG-side, already synchronised into `clk`) and the test sequencer both read and write the bank through a req/ack handshake. The arbiter serialises their accesses, with round-robin priority under contention. The block sits in the `clk` domain between the command decoder and the test state machine.

## Interface
Parameters:
- `NUM_REGS`, 8, number of 32-bit registers; need not be a power of two.
- `DATA_W`, 32, register width.
- `ADDR_W`, 4, address width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- `clk`  in  1  system clock; all logic is posedge.
- `notReset`  in  1  reset; one clock; reset is asynchronous and active-low.
- `hReq`  in  1  host request; held high until `hAck`.
- `hWe`  in  1  host write enable (1 = write, 0 = read).
- `hAddr`  in  ADDR_W  host register address.
- `hWdata`  in  DATA_W  host write data.
- `hAck`  out  1  host access complete; one-cycle pulse.
- `hRdata`  out  DATA_W  host read data; valid while `hAck` = 1, then held.
- `tReq`, `tWe`, `tAddr`, `tWdata`, `tAck`, `tRdata`: test-sequencer port, same semantics as the host port.
- `clearAll`  in  1  synchronous clear of every register; single-cycle pulse.
- `addrErr`  out  1  one-cycle pulse alongside an ack whose address was >= NUM_REGS.
- `busy`  out  1  high while state != IDLE.

## Operation
- States: IDLE, ACC_H, ACC_T.
- IDLE:
  - `clearAll` = 1: all registers are set to 0 and both requests are ignored this cycle; state stays IDLE.
  - Only `hReq` high → ACC_H. Only `tReq` high → ACC_T.
  - Both high → the port not granted last wins, and the `lastGrant` pointer updates.
  - On entry to ACC_x, `we`, `addr` and `wdata` of the winner are latched. Requester inputs may change after this edge.
- ACC_x:
  - Write: `regs[addr] <= wdata` if addr < NUM_REGS; out-of-range writes are dropped.
  - Read: `xRdata <= regs[addr]`, or 0 if out of range.
  - `xAck` pulses, and `addrErr` pulses if out of range. Next state is IDLE unconditionally.
  - `clearAll` during ACC_x is deferred: it is latched as pending and applied on the next IDLE cycle, before any grant.
- Handshake: the requester must deassert `req` by the edge following the cycle in which `ack` is high. A `req` still high at that edge is a new request.
- Fairness: `lastGrant` resets to T, so the host wins the first contention. With both requesters continuously requesting, grants strictly alternate H,T,H,T.
- Read-after-write: a read granted after a write to the same address returns the new value. There is no bypass path; it is not needed because accesses are serialised.
- `clearAll` and a write never take effect in the same cycle.

## Timing
- Reset (async, `notReset` = 0):
  - state = IDLE, all regs = 0.
  - `hAck` = `tAck` = `addrErr` = `busy` = 0, `hRdata` = `tRdata` = 0.
  - `lastGrant` = T, clear-pending = 0.
  - Reset asserted mid-access aborts the access: no ack and no write.
- Latency: `req` high at edge N (state IDLE) → ACC_x after N → access performed at edge N+1 → `ack`, `rdata` and `addrErr` high for exactly the cycle after N+1.
- Uncontended throughput is one access per 2 cycles. Under contention the loser is granted at edge N+2 and acks after N+3.
- `busy` is registered from state and is high exactly in the ACC_x cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then host write addr 3 = 0xDEADBEEF → `hAck` one cycle after the grant. Then test port reads addr 3 → `tRdata` = 0xDEADBEEF with `tAck`, and `hAck` stays 0.
- `hReq` and `tReq` rise in the same cycle, each a write to addr 1 (host 0x11, test 0x22) → host is acked first, test one access later; final regs[1] = 0x22.
- Both requesters held high for 8 accesses → ack order H,T,H,T,H,T,H,T with no ack gaps beyond 1 cycle.
- Host write addr 9 (NUM_REGS = 8) → `hAck` and `addrErr` pulse together and no register changes. Test read addr 9 → `tRdata` = 0, `addrErr` = 1.
- Write 0x5 to addr 2, then pulse `clearAll` while ACC_T is active → the clear applies at the next IDLE cycle, ahead of a pending `hReq` read of addr 2, which returns 0.
- Drive `notReset` low in the ACC_H cycle of a write of 0xA5 to addr 0 → no `hAck`, regs[0] = 0, `busy` = 0 immediately, and `busy` stays 0 until the first request after release.
